// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants and types for the round-robin mux arbiter
package mux_arb_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  localparam int DATA_W_DEF = 64;
  typedef enum logic {OPEN, LOCKED} arb_state_t;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux_arbiter_if.sv
// mux_arb_if: requester/consumer bundle for mux_arbiter; req_lock exists only with ARB_LOCK_EN
interface mux_arb_if
  import mux_arb_pkg::*;
#(parameter int DATA_W = DATA_W_DEF);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic [DATA_W-1:0] out_data;
  sel_t mux_sel;
`ifdef ARB_LOCK_EN
  logic [N_REQ-1:0] req_lock;
  modport master(output req_valid, req_data, req_lock, out_ready,
                 input req_ready, out_valid, out_data, mux_sel, busy);
  modport slave(input req_valid, req_data, req_lock, out_ready,
                output req_ready, out_valid, out_data, mux_sel, busy);
`else
  modport master(output req_valid, req_data, out_ready,
                 input req_ready, out_valid, out_data, mux_sel, busy);
  modport slave(input req_valid, req_data, out_ready,
                output req_ready, out_valid, out_data, mux_sel, busy);
`endif
endinterface

// File: rtl/mux_arbiter_rr_pick.sv
// rr_pick: rotate-priority picker, first set request searching upward from ptr+1 mod 4
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  output sel_t             idx,
  output logic             found
);
  always_comb begin
    idx = '0;
    found = 1'b0;
    // walk from farthest to nearest so the nearest hit wins
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[ptr + sel_t'(k)]) begin
        idx = ptr + sel_t'(k);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin 4:1 arbiter with registered output stage; ARB_LOCK_EN adds locked bursts
module mux_arbiter
  import mux_arb_pkg::*;
#(parameter int DATA_W = DATA_W_DEF)
(
  input logic clk,
  input logic rst_n,
  mux_arb_if.slave bus
);
  sel_t ptr, idx, sel_q;
  logic found, free, grant, ov;
  logic [N_REQ-1:0] elig;
  logic [DATA_W-1:0] od, word;
`ifdef ARB_LOCK_EN
  arb_state_t state, state_n;
  sel_t owner, owner_n;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= OPEN;
      owner <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
    end
  // every grant re-evaluates the lock from the winner's req_lock bit
  always_comb begin
    state_n = state;
    owner_n = owner;
    if (grant) begin
      state_n = bus.req_lock[idx] ? LOCKED : OPEN;
      owner_n = idx;
    end
  end
  assign elig = state == LOCKED ? bus.req_valid & (N_REQ'(1) << owner) : bus.req_valid;
  assign bus.busy = ov | (state == LOCKED);
`else
  assign elig = bus.req_valid;
  assign bus.busy = ov;
`endif
  rr_pick u_pick (.req(elig), .ptr(ptr), .idx(idx), .found(found));
  assign free = !ov | bus.out_ready;
  assign grant = rst_n & free & found;
  assign bus.req_ready = grant ? N_REQ'(1) << idx : '0;
  assign word = bus.req_data[int'(idx)*DATA_W +: DATA_W];
  always_ff @(posedge clk)
    if (!rst_n) begin
      ov <= 1'b0;
      od <= '0;
      sel_q <= '0;
      ptr <= sel_t'(N_REQ - 1);
    end else if (grant) begin
      ov <= 1'b1;
      od <= word;
      sel_q <= idx;
      ptr <= idx;
    end else if (bus.out_ready) begin
      ov <= 1'b0;
    end
  assign bus.out_valid = ov;
  assign bus.out_data = od;
  assign bus.mux_sel = sel_q;
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed plus random stimulus checked against a behavioural arbiter model
module tb_mux_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int m_ptr = 3;
  int m_sel = 0;
  bit m_ov = 0;
  bit m_locked = 0;
  int m_owner = 0;
  logic [63:0] m_od = '0;

  always #5 clk = ~clk;

  mux_arb_if #(.DATA_W(64)) bus ();
  mux_arbiter #(.DATA_W(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int winner();
    if (!rst_n || !(!m_ov || bus.out_ready)) return -1;
    for (int k = 1; k <= 4; k++) begin
      int i = (m_ptr + k) % 4;
      if (bus.req_valid[i] && (!m_locked || i == m_owner)) return i;
    end
    return -1;
  endfunction

  task automatic cycle();
    int w;
    #1;
    w = winner();
    chk("req_ready", 64'(bus.req_ready), (w >= 0) ? (64'd1 << w) : 64'd0);
    @(posedge clk);
    if (!rst_n) begin
      m_ov = 0; m_od = '0; m_sel = 0; m_ptr = 3; m_locked = 0; m_owner = 0;
    end else if (w >= 0) begin
      m_ov = 1; m_od = bus.req_data[w*64 +: 64]; m_sel = w; m_ptr = w;
`ifdef ARB_LOCK_EN
      m_locked = bus.req_lock[w]; m_owner = w;
`endif
    end else if (bus.out_ready) m_ov = 0;
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
    chk("out_data", bus.out_data, m_od);
    chk("mux_sel", 64'(bus.mux_sel), 64'(m_sel));
    chk("busy", 64'(bus.busy), 64'(m_ov || m_locked));
    @(negedge clk);
  endtask

  task automatic set_lock(input logic [3:0] v);
`ifdef ARB_LOCK_EN
    bus.req_lock = v;
`endif
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.out_ready = 1'b0;
    set_lock(4'b0);
    @(negedge clk);
    cycle();
    cycle();
    // single requester, first grant after reset goes to 0
    rst_n = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_data[63:0] = 64'hA;
    bus.out_ready = 1'b1;
    #1 chk("t1_ready_now", 64'(bus.req_ready), 64'h1);
    cycle();
    chk("t1_data", bus.out_data, 64'hA);
    chk("t1_valid", 64'(bus.out_valid), 64'h1);
    // rotation 0..3 from a fresh reset
    rst_n = 1'b0;
    bus.req_valid = '0;
    cycle();
    rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) bus.req_data[i*64 +: 64] = 64'h10 + 64'(i);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t2_data", bus.out_data, 64'h10 + 64'(i));
      chk("t2_sel", 64'(bus.mux_sel), 64'(i));
    end
    // backpressure hold then release to the index after the holder
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3_hold", bus.out_data, 64'h13);
    end
    bus.out_ready = 1'b1;
    cycle();
    chk("t3_release", 64'(bus.mux_sel), 64'h0);
    // wrap after a grant to 3
    bus.req_valid = 4'b1000;
    cycle();
    bus.req_valid = 4'b1001;
    cycle();
    chk("t4_wrap", 64'(bus.mux_sel), 64'h0);
`ifdef ARB_LOCK_EN
    bus.req_valid = 4'b0010;
    cycle();
    bus.req_valid = 4'b0110;
    set_lock(4'b0100);
    cycle();
    cycle();
    set_lock(4'b0000);
    cycle();
    chk("t5_owner", 64'(bus.mux_sel), 64'h2);
    cycle();
    chk("t5_next", 64'(bus.mux_sel), 64'h1);
    bus.req_valid = 4'b0100;
    set_lock(4'b0100);
    cycle();
`endif
    // reset while holding a word (and a lock when compiled in)
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    cycle();
    chk("t6_valid", 64'(bus.out_valid), 64'h0);
    chk("t6_data", bus.out_data, 64'h0);
    rst_n = 1'b1;
    set_lock(4'b0000);
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b1;
    cycle();
    chk("t6_pref0", 64'(bus.mux_sel), 64'h0);
    for (int n = 0; n < 400; n++) begin
      bus.req_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) bus.req_data[i*64 +: 64] = {$urandom, $urandom};
      bus.out_ready = $urandom_range(0, 3) != 0;
      set_lock({$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0});
      rst_n = $urandom_range(0, 49) != 0;
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
